// File: rtl/input_debounce_capture.sv
// input_debounce_capture
//   Front-end conditioning for the square-root calculator. Synchronises and
//   debounces the start/step push-buttons, produces single-cycle start/step
//   pulses (step auto-repeats while held), and captures the 14-bit operand on
//   an accepted start.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   ui_in    in 8 [0] start button, [1] step button, [7:2] operand low bits
//   uio_in   in 8 operand high bits
//   ready    in   downstream engine can accept start
//   start    out  one-cycle pulse, operand accepted
//   step     out  one-cycle pulse, advance display digit (auto-repeats)
//   operand  out 14 last accepted operand {uio_in, ui_in[7:2]}
//   dropped  out  sticky: a start press arrived while ready was low
//   held     out 2 debounced button levels {step_db, start_db}
module input_debounce_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  input  logic        ready,
  output logic        start,
  output logic        step,
  output logic [13:0] operand,
  output logic        dropped,
  output logic [1:0]  held
);

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
  // One repeat counter serves both DELAY and REPEAT, so size it for the larger.
  localparam int unsigned RcMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcW   = $clog2(RcMax);

  localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RcW-1:0]  DelayLast  = RcW'(REPEAT_DELAY - 1);
  localparam logic [RcW-1:0]  PeriodLast = RcW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} step_state_e;

  logic [1:0]           r_sync1, r_sync2;
  logic [1:0]           r_db;
  logic [1:0][CntW-1:0] r_cnt;
  logic [1:0]           w_db_d;
  logic [1:0][CntW-1:0] w_cnt_d;
  logic [1:0]           w_db_rise;

  logic                 r_start;
  logic [13:0]          r_operand;
  logic                 r_dropped;

  step_state_e          r_state, w_state_d;
  logic [RcW-1:0]       r_rc, w_rc_d;
  logic                 r_step, w_step_d;

  // Debounce next-state. The rise strobe fires on the same edge db flips to 1,
  // so the pulses below land in the cycle right after that edge.
  always_comb begin
    w_db_d    = r_db;
    w_cnt_d   = '0;
    w_db_rise = '0;
    for (int b = 0; b < 2; b++) begin
      if (r_sync2[b] != r_db[b]) begin
        if (r_cnt[b] == CntLast) begin
          w_db_d[b]    = r_sync2[b];
          w_db_rise[b] = r_sync2[b];
        end else begin
          w_cnt_d[b] = r_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= ui_in[1:0];
      r_sync2 <= r_sync1;
      r_db    <= w_db_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Start path: a rise with ready low is recorded as dropped, never retried.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start   <= 1'b0;
      r_operand <= '0;
      r_dropped <= 1'b0;
    end else if (w_db_rise[0]) begin
      if (ready) begin
        r_start   <= 1'b1;
        r_operand <= {uio_in, ui_in[7:2]};
        r_dropped <= 1'b0;
      end else begin
        r_start   <= 1'b0;
        r_dropped <= 1'b1;
      end
    end else begin
      r_start <= 1'b0;
    end
  end

  // Step FSM: release (db low) wins over a pulse due in the same cycle.
  always_comb begin
    w_state_d = r_state;
    w_rc_d    = r_rc;
    w_step_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_db_rise[1]) begin
          w_step_d  = 1'b1;
          w_rc_d    = '0;
          w_state_d = StDelay;
        end
      end
      StDelay: begin
        if (!r_db[1]) begin
          w_rc_d    = '0;
          w_state_d = StIdle;
        end else if (r_rc == DelayLast) begin
          w_step_d  = 1'b1;
          w_rc_d    = '0;
          w_state_d = StRepeat;
        end else begin
          w_rc_d = r_rc + 1'b1;
        end
      end
      StRepeat: begin
        if (!r_db[1]) begin
          w_rc_d    = '0;
          w_state_d = StIdle;
        end else if (r_rc == PeriodLast) begin
          w_step_d = 1'b1;
          w_rc_d   = '0;
        end else begin
          w_rc_d = r_rc + 1'b1;
        end
      end
      default: begin
        w_rc_d    = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_rc    <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rc    <= w_rc_d;
      r_step  <= w_step_d;
    end
  end

  assign start   = r_start;
  assign step    = r_step;
  assign operand = r_operand;
  assign dropped = r_dropped;
  assign held    = r_db;

endmodule

// File: tb/tb_input_debounce_capture.sv
// Testbench for input_debounce_capture with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3. Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, i.e. they reflect the state after that edge.
module tb_input_debounce_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uio_in;
  logic        ready;
  logic        start;
  logic        step;
  logic [13:0] operand;
  logic        dropped;
  logic [1:0]  held;

  int checks = 0;
  int errors = 0;

  input_debounce_capture #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .ready  (ready),
    .start  (start),
    .step   (step),
    .operand(operand),
    .dropped(dropped),
    .held   (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;       // cycles to apply; same expectation every cycle
    logic        rst_n;
    logic [7:0]  ui;
    logic [7:0]  uio;
    logic        rdy;
    logic        e_start;
    logic        e_step;
    logic [13:0] e_op;
    logic        e_drop;
    logic [1:0]  e_held;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input int n, input logic rn,
                              input logic [7:0] ui, input logic [7:0] uio, input logic rdy,
                              input logic es, input logic est, input logic [13:0] eop,
                              input logic ed, input logic [1:0] eh);
    vec_t v;
    v.name = name; v.n = n; v.rst_n = rn; v.ui = ui; v.uio = uio; v.rdy = rdy;
    v.e_start = es; v.e_step = est; v.e_op = eop; v.e_drop = ed; v.e_held = eh;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic es, input logic est,
                           input logic [13:0] eop, input logic ed, input logic [1:0] eh);
    check({name, ".start"},   16'(start),   16'(es));
    check({name, ".step"},    16'(step),    16'(est));
    check({name, ".operand"}, 16'(operand), 16'(eop));
    check({name, ".dropped"}, 16'(dropped), 16'(ed));
    check({name, ".held"},    16'(held),    16'(eh));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    logic exp_step;

    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ready  = 1'b1;

    //   name          n  rn  ui     uio    rdy st sp op       dr held
    add("reset",       2, 0, 8'h00, 8'h00, 1, 0, 0, 14'h0000, 0, 2'b00);
    // Accepted start: operand {A5, 3C} = 0x297C, pulse after edge t+5.
    add("acc_wait",    5, 1, 8'hF1, 8'hA5, 1, 0, 0, 14'h0000, 0, 2'b00);
    add("acc_pulse",   1, 1, 8'hF1, 8'hA5, 1, 1, 0, 14'h297C, 0, 2'b01);
    add("acc_after",   1, 1, 8'hF1, 8'hA5, 1, 0, 0, 14'h297C, 0, 2'b01);
    add("acc_rel",     5, 1, 8'hF0, 8'hA5, 1, 0, 0, 14'h297C, 0, 2'b01);
    add("acc_reldone", 1, 1, 8'hF0, 8'hA5, 1, 0, 0, 14'h297C, 0, 2'b00);
    // Glitch: 3-cycle press must not flip db nor capture new operand bits.
    add("glitch_hi",   3, 1, 8'h01, 8'h11, 1, 0, 0, 14'h297C, 0, 2'b00);
    add("glitch_lo",   6, 1, 8'h00, 8'h11, 1, 0, 0, 14'h297C, 0, 2'b00);
    // Dropped start with ready low.
    add("drop_wait",   5, 1, 8'h01, 8'h11, 0, 0, 0, 14'h297C, 0, 2'b00);
    add("drop_edge",   1, 1, 8'h01, 8'h11, 0, 0, 0, 14'h297C, 1, 2'b01);
    add("drop_hold",   1, 1, 8'h01, 8'h11, 0, 0, 0, 14'h297C, 1, 2'b01);
    add("drop_rel",    5, 1, 8'h00, 8'h11, 0, 0, 0, 14'h297C, 1, 2'b01);
    add("drop_reldn",  1, 1, 8'h00, 8'h11, 0, 0, 0, 14'h297C, 1, 2'b00);
    // Retry with ready high: operand {01, 02} = 0x042, dropped clears.
    add("retry_wait",  5, 1, 8'h09, 8'h01, 1, 0, 0, 14'h297C, 1, 2'b00);
    add("retry_pulse", 1, 1, 8'h09, 8'h01, 1, 1, 0, 14'h0042, 0, 2'b01);
    add("retry_after", 1, 1, 8'h09, 8'h01, 1, 0, 0, 14'h0042, 0, 2'b01);
    add("retry_rel",   5, 1, 8'h08, 8'h01, 1, 0, 0, 14'h0042, 0, 2'b01);
    add("retry_reldn", 1, 1, 8'h08, 8'h01, 1, 0, 0, 14'h0042, 0, 2'b00);

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        rst_n  = tbl[i].rst_n;
        ui_in  = tbl[i].ui;
        uio_in = tbl[i].uio;
        ready  = tbl[i].rdy;
        tick();
        check_all($sformatf("%s[%0d]", tbl[i].name, j), tbl[i].e_start, tbl[i].e_step,
                  tbl[i].e_op, tbl[i].e_drop, tbl[i].e_held);
      end
    end

    // Step auto-repeat: press first sampled at k=0, s at k=5, release sampled
    // at k=30 so step_db falls at s+30. Pulses at s, s+8, s+11, ... s+29.
    ui_in = 8'h0A;
    for (int k = 0; k < 46; k++) begin
      if (k == 30) ui_in = 8'h08;
      tick();
      d = k - 5;
      exp_step = (d == 0) || (d >= 8 && d <= 30 && ((d - 8) % 3) == 0);
      check($sformatf("rep_step[%0d]", k), 16'(step), 16'(exp_step));
      check($sformatf("rep_held1[%0d]", k), 16'(held[1]), 16'(d >= 0 && d < 30));
    end
    check("rep_start", 16'(start), 16'(1'b0));

    // Simultaneous presses: operand {02, 01} = 0x081.
    ui_in  = 8'h07;
    uio_in = 8'h02;
    ready  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 5) begin
        check($sformatf("sim_start0[%0d]", k), 16'(start), 16'(1'b0));
        check($sformatf("sim_step0[%0d]", k), 16'(step), 16'(1'b0));
      end
    end
    check_all("sim_pulse", 1'b1, 1'b1, 14'h0081, 1'b0, 2'b11);
    ui_in = 8'h04;
    repeat (20) tick();
    check_all("sim_idle", 1'b0, 1'b0, 14'h0081, 1'b0, 2'b00);

    // Reset while step is held in REPEAT; pulse at k=13 confirms REPEAT entry.
    ui_in = 8'h06;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 13) check("rst_pre_repeat", 16'(step), 16'(1'b1));
    end
    rst_n = 1'b0;
    tick();
    check_all("rst_in0", 1'b0, 1'b0, 14'h0000, 1'b0, 2'b00);
    tick();
    check_all("rst_in1", 1'b0, 1'b0, 14'h0000, 1'b0, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rst_post_step[%0d]", k), 16'(step), 16'(k == 5));
      check($sformatf("rst_post_held[%0d]", k), 16'(held), (k == 5) ? 16'h2 : 16'h0);
    end
    check("rst_post_op", 16'(operand), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debounce_capture.md
# input_debounce_capture

Front-end conditioning stage for the square-root calculator. It synchronises and debounces the two push-buttons on `ui_in[1:0]` and turns them into single-cycle `start` and `step` pulses, with auto-repeat on `step`. On an accepted `start` it captures the 14-bit operand `{uio_in, ui_in[7:2]}`. It feeds the downstream root engine (`start`, `operand`, `ready`) and the digit-select counter of the display stage (`step`).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronised input must differ from its debounced level before that level flips (≥2).
- `REPEAT_DELAY`, 64: cycles from the first `step` pulse to the first auto-repeat pulse (≥2).
- `REPEAT_PERIOD`, 16: cycles between subsequent auto-repeat pulses (≥2).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ui_in` in 8: bit0 = start button, bit1 = step button, bits[7:2] = operand low bits.
- `uio_in` in 8: operand high bits.
- `ready` in 1: downstream engine is idle and can accept `start`.
- `start` out 1: one-cycle pulse, operand accepted.
- `step` out 1: one-cycle pulse, advance display digit.
- `operand` out 14: last accepted operand, `{uio_in, ui_in[7:2]}`.
- `dropped` out 1: sticky; a start press occurred while `ready`=0.
- `held` out 2: debounced button levels, `{step_db, start_db}`.

## Operation
- Sync: `ui_in[1:0]` pass through a 2-flop synchroniser. The operand bits are sampled unsynchronised; the user holds them static.
- Debounce, per button: level `db` and counter `cnt`.
  - If sync == `db`: `cnt` <= 0.
  - Else if `cnt` == `DEBOUNCE_CYCLES`-1: `db` <= sync and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - A mismatch shorter than `DEBOUNCE_CYCLES` cycles changes nothing.
- Start path, on the edge where `start_db` goes 0→1:
  - If `ready`=1: `start` <= 1, `operand` <= `{uio_in, ui_in[7:2]}`, `dropped` <= 0.
  - If `ready`=0: `start` stays 0, `operand` is unchanged, `dropped` <= 1.
  - Otherwise `start` <= 0.
  - The falling edge of `start_db` has no effect.
- Step FSM, states IDLE, DELAY, REPEAT, with a repeat counter `rc`:
  - IDLE: on `step_db` 0→1, `step` <= 1, `rc` <= 0, go to DELAY.
  - DELAY: `rc` increments each cycle. When `rc` == `REPEAT_DELAY`-1, `step` <= 1, `rc` <= 0, go to REPEAT.
  - REPEAT: when `rc` == `REPEAT_PERIOD`-1, `step` <= 1 and `rc` <= 0.
  - DELAY or REPEAT: if `step_db` == 0, go to IDLE, `rc` <= 0, no pulse. This takes priority over a pulse due in the same cycle.
- The start and step paths are independent. Both pulses may be high in the same cycle.
- Counter widths: `$clog2` of the respective parameter. Counters never wrap, because each is cleared at its terminal value.

## Timing
- Reset values: `start`=0, `step`=0, `operand`=0, `dropped`=0, `held`=0. Synchroniser flops, `db`, `cnt` and `rc` are all 0, and the FSM is in IDLE.
- Press latency: if `ui_in[b]`=1 is first sampled at edge t and held, `db` is 1 after edge t+`DEBOUNCE_CYCLES`+1. The pulse is high for the cycle following that edge. Release latency is identical.
- `ready` and the operand bits are sampled at that same edge.
- `step` pulses land at edges s, s+`REPEAT_DELAY`, then every `REPEAT_PERIOD`, where s is the `step_db` rise edge. Pulses continue until `step_db` falls, which can be up to `DEBOUNCE_CYCLES`+1 cycles after physical release.
- Reset mid-operation: all state clears at once. A button held through reset deasserts nothing, re-debounces from 0, and produces a fresh pulse.
- `start` is never asserted when the debounced rise coincides with `ready`=0. It is not retried later.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=3.

- **Accepted start.** Set `uio_in`=0xA5 and `ui_in[7:2]`=0x3C. Raise `ui_in[0]`, first sampled at edge t, with `ready`=1. Expect `start`=1 for exactly one cycle after edge t+5, `operand`=0x297C, and `dropped`=0.
- **Glitch rejection.** Pulse `ui_in[0]` high for 3 cycles, then low. Expect no `start`, `held[0]`=0, and `operand` unchanged.
- **Dropped start.** Press with `ready`=0. Expect no `start`, `dropped`=1, and `operand` to keep its prior value. Release, set `ready`=1, press again. Expect `start` to pulse and `dropped` to return to 0.
- **Step auto-repeat.** Hold `ui_in[1]` for 30 cycles. With s the `step_db` rise edge, expect pulses at s, s+8, s+11, s+14 … until `held[1]` falls, then none.
- **Simultaneous presses.** Raise `ui_in[1:0]` on the same edge with `ready`=1. Expect `start` and `step` both high in the same cycle.
- **Reset mid-press.** Assert `rst_n`=0 for 2 cycles while `ui_in[1]` is held in the REPEAT state. Expect all outputs 0 during reset. After release, expect a new `step` pulse after edge r+5, where r is the first edge with `rst_n`=1.
